// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer: prescaler, auto-reload counter, sticky flag, level irq.
// Optional prescaler enabled with `define TIMER_PRESCALER_EN; otherwise every enabled cycle ticks.
module timer_dev #(
    parameter int CNT_W = 32,
    parameter int PSC_W = 16
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        we_from_bridge,
    input  logic [4:0]  addr_from_bridge,
    input  logic [31:0] wdata_from_bridge,
    output logic [31:0] rdata_to_bridge,
    output logic        irq
);
    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_PSC    = 3'd1;
    localparam logic [2:0] A_RELOAD = 3'd2;
    localparam logic [2:0] A_COUNT  = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic [2:0] sel;
    logic       wr_ctrl, wr_reload, wr_count, wr_status;
    logic       en, ar, ie, flag;
    logic       en_d, ie_d, flag_d;
    logic       tick, underflow;
    logic [CNT_W-1:0] count, reload;
    logic [31:0] psc_rd;
    logic       unused_addr;

    assign sel         = addr_from_bridge[4:2];
    assign unused_addr = ^addr_from_bridge[1:0];
    assign wr_ctrl     = we_from_bridge && (sel == A_CTRL);
    assign wr_reload   = we_from_bridge && (sel == A_RELOAD);
    assign wr_count    = we_from_bridge && (sel == A_COUNT);
    assign wr_status   = we_from_bridge && (sel == A_STATUS);
    assign underflow   = tick && (count == '0);

`ifdef TIMER_PRESCALER_EN
    logic             wr_psc;
    logic [PSC_W-1:0] prescale, psc;

    assign wr_psc = we_from_bridge && (sel == A_PSC);
    assign tick   = en && (psc == prescale);
    assign psc_rd = 32'(prescale);

    // psc restarts whenever the time base is redefined, and rests at 0 while disabled.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            prescale <= '0;
            psc      <= '0;
        end else begin
            if (wr_psc)
                prescale <= wdata_from_bridge[PSC_W-1:0];
            if (wr_psc || wr_count || (wr_ctrl && wdata_from_bridge[0] && !en) || tick || !en_d)
                psc <= '0;
            else
                psc <= psc + 1'b1;
        end
    end
`else
    assign tick   = en;
    assign psc_rd = '0;
`endif

    always_comb begin
        en_d = en;
        if (wr_ctrl)
            en_d = wdata_from_bridge[0];
        else if (underflow && !ar)
            en_d = 1'b0;

        ie_d = wr_ctrl ? wdata_from_bridge[2] : ie;

        // Underflow wins over a coincident W1C so the event is never lost.
        flag_d = flag;
        if (underflow)
            flag_d = 1'b1;
        else if (wr_status && wdata_from_bridge[0])
            flag_d = 1'b0;
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            en     <= 1'b0;
            ar     <= 1'b0;
            ie     <= 1'b0;
            flag   <= 1'b0;
            irq    <= 1'b0;
            count  <= '0;
            reload <= '0;
        end else begin
            en   <= en_d;
            ie   <= ie_d;
            flag <= flag_d;
            irq  <= flag_d & ie_d;
            if (wr_ctrl)
                ar <= wdata_from_bridge[1];
            if (wr_reload)
                reload <= wdata_from_bridge[CNT_W-1:0];
            // A bus write to COUNT overrides any decrement or reload this cycle.
            if (wr_count)
                count <= wdata_from_bridge[CNT_W-1:0];
            else if (tick) begin
                if (count != '0)
                    count <= count - 1'b1;
                else if (ar)
                    count <= reload;
            end
        end
    end

    always_comb begin
        rdata_to_bridge = '0;
        case (sel)
            A_CTRL:   rdata_to_bridge = {29'd0, ie, ar, en};
            A_PSC:    rdata_to_bridge = psc_rd;
            A_RELOAD: rdata_to_bridge = 32'(reload);
            A_COUNT:  rdata_to_bridge = 32'(count);
            A_STATUS: rdata_to_bridge = {31'd0, flag};
            default:  rdata_to_bridge = '0;
        endcase
    end
endmodule
